// File: rtl/dm_access_unit.sv
// dm_access_unit: byte-addressed load/store initiator for the data memory.
// One request is taken in IDLE, performs a single ACCESS (or FAULT) cycle
// against the word-wide dm ports, then holds its response in RESP until
// the consumer takes it. Sub-word stores merge into the word read back
// from dm within the same ACCESS cycle.
module dm_access_unit #(
   parameter int ADDR_WIDTH         = 12,
   parameter int DM_WORD_ADDR_WIDTH = ADDR_WIDTH - 2
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_write,
   input  logic [1:0]                    req_size,
   input  logic                          req_signed,
   input  logic [ADDR_WIDTH-1:0]         req_addr,
   input  logic [31:0]                   req_wdata,
   output logic                          resp_valid,
   input  logic                          resp_ready,
   output logic [31:0]                   resp_rdata,
   output logic                          resp_fault,
   output logic [DM_WORD_ADDR_WIDTH-1:0] dm_read_addr,
   input  logic [31:0]                   dm_read_result,
   output logic [DM_WORD_ADDR_WIDTH-1:0] dm_write_addr,
   output logic [31:0]                   dm_write_data,
   output logic                          dm_write_enable
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_FAULT, S_RESP} state_t;

   state_t                state_q, state_d;
   logic                  wr_q, wr_d;
   logic [1:0]            size_q, size_d;
   logic                  sgn_q, sgn_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  fault_q, fault_d;
   logic [31:0]           load_val;
   logic [31:0]           merge_val;

   // Size 3 is never legal; half needs even address, word needs addr[1:0]=0.
   function automatic logic bad_req(input logic [1:0] sz, input logic [1:0] lo);
      logic bad;
      case (sz)
         2'd0:    bad = 1'b0;
         2'd1:    bad = lo[0];
         2'd2:    bad = |lo;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Pick the addressed lane(s) out of a little-endian word and extend.
   function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                                input logic sg, input logic [1:0] lo);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      case (lo)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = lo[1] ? w[31:16] : w[15:0];
      case (sz)
         2'd0:    res = {{24{sg & b[7]}}, b};
         2'd1:    res = {{16{sg & h[15]}}, h};
         default: res = w;
      endcase
      return res;
   endfunction

   // Replace the addressed lane(s) of the current dm word with store data.
   function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                               input logic [1:0] sz, input logic [1:0] lo);
      logic [31:0] m;
      m = w;
      case (sz)
         2'd0: begin
            case (lo)
               2'd0:    m[7:0]   = d[7:0];
               2'd1:    m[15:8]  = d[7:0];
               2'd2:    m[23:16] = d[7:0];
               default: m[31:24] = d[7:0];
            endcase
         end
         2'd1: begin
            if (lo[1]) m[31:16] = d[15:0];
            else       m[15:0]  = d[15:0];
         end
         default: m = d;
      endcase
      return m;
   endfunction

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state decode; ACCESS and FAULT are single-cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) state_d = bad_req(req_size, req_addr[1:0]) ? S_FAULT : S_ACCESS;
         end
         S_ACCESS: state_d = S_RESP;
         S_FAULT:  state_d = S_RESP;
         S_RESP: begin
            if (resp_ready) state_d = S_IDLE;
         end
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state so the write strobe drops at once on reset.
   always_comb begin
      req_ready       = (state_q == S_IDLE);
      resp_valid      = (state_q == S_RESP);
      dm_write_enable = (state_q == S_ACCESS) && wr_q;
      dm_write_data   = dm_write_enable ? merge_val : 32'd0;
      dm_read_addr    = addr_q[DM_WORD_ADDR_WIDTH+1:2];
      dm_write_addr   = addr_q[DM_WORD_ADDR_WIDTH+1:2];
      resp_rdata      = rdata_q;
      resp_fault      = fault_q;
   end

   // Load extraction and store merge against the live dm read word.
   always_comb begin
      load_val  = load_extract(dm_read_result, size_q, sgn_q, addr_q[1:0]);
      merge_val = store_merge(dm_read_result, wdata_q, size_q, addr_q[1:0]);
   end

   // Request capture in IDLE and response capture at the end of ACCESS/FAULT.
   always_comb begin
      wr_d    = wr_q;
      size_d  = size_q;
      sgn_d   = sgn_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      fault_d = fault_q;
      if (state_q == S_IDLE && req_valid) begin
         wr_d    = req_write;
         size_d  = req_size;
         sgn_d   = req_signed;
         addr_d  = req_addr;
         wdata_d = req_wdata;
      end
      if (state_q == S_ACCESS) begin
         rdata_d = wr_q ? 32'd0 : load_val;
         fault_d = 1'b0;
      end
      if (state_q == S_FAULT) begin
         rdata_d = 32'd0;
         fault_d = 1'b1;
      end
   end

   // Request and response registers; cleared so outputs read zero after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q    <= 1'b0;
         size_q  <= 2'd0;
         sgn_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         fault_q <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         size_q  <= size_d;
         sgn_q   <= sgn_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
      end
   end

endmodule

// File: tb/tb_dm_access_unit.sv
// Testbench for dm_access_unit: models the dm word array, drives requests
// and checks responses against a scoreboard of expected {fault, rdata}.
module tb_dm_access_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [9:0]  dm_read_addr;
   logic [31:0] dm_read_result;
   logic [9:0]  dm_write_addr;
   logic [31:0] dm_write_data;
   logic        dm_write_enable;

   logic [31:0] mem [0:1023];
   int          we_cnt = 0;
   int          n_vec = 0;
   int          n_err = 0;
   logic [32:0] sb_q [$];

   dm_access_unit #(.ADDR_WIDTH(12), .DM_WORD_ADDR_WIDTH(10)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_fault(resp_fault),
      .dm_read_addr(dm_read_addr), .dm_read_result(dm_read_result),
      .dm_write_addr(dm_write_addr), .dm_write_data(dm_write_data),
      .dm_write_enable(dm_write_enable)
   );

   always #5 clk = ~clk;

   assign dm_read_result = mem[dm_read_addr];

   always @(posedge clk) begin
      if (dm_write_enable) begin
         mem[dm_write_addr] <= dm_write_data;
         we_cnt <= we_cnt + 1;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Full transaction with resp_ready held high; checks latency and response.
   task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [11:0] a, input logic [31:0] wd,
                         input logic [31:0] erd, input logic ef, input string nm);
      int waited;
      int lat;
      logic [32:0] exp;
      sb_q.push_back({ef, erd});
      @(negedge clk);
      req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
      req_valid = 1'b1; resp_ready = 1'b1;
      waited = 0;
      while (!req_ready && waited < 20) begin @(negedge clk); waited++; end
      n_vec++;
      if (req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL %s accept: req_ready=%b required 1 within 20 cycles", nm, req_ready);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
      n_vec++;
      if (lat !== 2) begin
         n_err++;
         $display("FAIL %s latency: got %0d cycles, required 2", nm, lat);
      end
      exp = sb_q.pop_front();
      n_vec++;
      if (resp_rdata !== exp[31:0]) begin
         n_err++;
         $display("FAIL %s rdata: got %h required %h", nm, resp_rdata, exp[31:0]);
      end
      n_vec++;
      if (resp_fault !== exp[32]) begin
         n_err++;
         $display("FAIL %s fault: got %b required %b", nm, resp_fault, exp[32]);
      end
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({resp_valid, req_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL %s release: {resp_valid,req_ready}=%b required 01", nm, {resp_valid, req_ready});
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
      req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({req_ready, resp_valid, resp_fault, dm_write_enable} !== 4'b1000) begin
         n_err++;
         $display("FAIL reset_ctrl: {rdy,rvld,flt,we}=%b required 1000",
                  {req_ready, resp_valid, resp_fault, dm_write_enable});
      end
      n_vec++;
      if ({resp_rdata, dm_write_data, dm_read_addr, dm_write_addr} !== 84'd0) begin
         n_err++;
         $display("FAIL reset_data: rdata=%h wdata=%h raddr=%h waddr=%h required all 0",
                  resp_rdata, dm_write_data, dm_read_addr, dm_write_addr);
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_word();
      int c0;
      do_req(1'b1, 2'd2, 1'b0, 12'h020, 32'h13579BDF, 32'h0, 1'b0, "sw_020");
      c0 = we_cnt;
      do_req(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, 32'h0, 1'b0, "sw_010");
      do_req(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 32'hDEADBEEF, 1'b0, "lw_010");
      n_vec++;
      if (we_cnt - c0 !== 1) begin
         n_err++;
         $display("FAIL word_we_pulses: got %0d required 1", we_cnt - c0);
      end
      n_vec++;
      if (mem[4] !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL word_mem: got %h required DEADBEEF", mem[4]);
      end
   endtask

   task automatic test_subword_store();
      do_req(1'b1, 2'd0, 1'b0, 12'h012, 32'hFFFFFF55, 32'h0, 1'b0, "sb_012");
      n_vec++;
      if (mem[4] !== 32'hDE55BEEF) begin
         n_err++;
         $display("FAIL sb_mem: got %h required DE55BEEF", mem[4]);
      end
      do_req(1'b1, 2'd1, 1'b0, 12'h010, 32'hABCD1234, 32'h0, 1'b0, "sh_010");
      n_vec++;
      if (mem[4] !== 32'hDE551234) begin
         n_err++;
         $display("FAIL sh_mem: got %h required DE551234", mem[4]);
      end
   endtask

   task automatic test_loads();
      do_req(1'b0, 2'd0, 1'b1, 12'h013, 32'h0, 32'hFFFFFFDE, 1'b0, "lb_013");
      do_req(1'b0, 2'd0, 1'b0, 12'h013, 32'h0, 32'h000000DE, 1'b0, "lbu_013");
      do_req(1'b0, 2'd0, 1'b0, 12'h011, 32'h0, 32'h00000012, 1'b0, "lbu_011");
      do_req(1'b0, 2'd0, 1'b1, 12'h010, 32'h0, 32'h00000034, 1'b0, "lb_010");
      do_req(1'b0, 2'd1, 1'b1, 12'h012, 32'h0, 32'hFFFFDE55, 1'b0, "lh_012");
      do_req(1'b0, 2'd1, 1'b0, 12'h010, 32'h0, 32'h00001234, 1'b0, "lhu_010");
      do_req(1'b0, 2'd1, 1'b1, 12'h010, 32'h0, 32'h00001234, 1'b0, "lh_010");
      do_req(1'b0, 2'd2, 1'b1, 12'h010, 32'h0, 32'hDE551234, 1'b0, "lw_signed");
   endtask

   task automatic test_faults();
      int c0;
      c0 = we_cnt;
      do_req(1'b1, 2'd2, 1'b0, 12'h012, 32'h11111111, 32'h0, 1'b1, "sw_012");
      do_req(1'b0, 2'd1, 1'b1, 12'h011, 32'h0, 32'h0, 1'b1, "lh_011");
      do_req(1'b0, 2'd3, 1'b0, 12'h000, 32'h0, 32'h0, 1'b1, "size3_000");
      do_req(1'b1, 2'd1, 1'b0, 12'h013, 32'h22222222, 32'h0, 1'b1, "sh_013");
      n_vec++;
      if (we_cnt !== c0) begin
         n_err++;
         $display("FAIL fault_no_write: got %0d pulses required 0", we_cnt - c0);
      end
      n_vec++;
      if (mem[4] !== 32'hDE551234) begin
         n_err++;
         $display("FAIL fault_mem: got %h required DE551234", mem[4]);
      end
   endtask

   task automatic test_top_word();
      do_req(1'b1, 2'd2, 1'b0, 12'hFFC, 32'hCAFEF00D, 32'h0, 1'b0, "sw_FFC");
      do_req(1'b0, 2'd0, 1'b1, 12'hFFE, 32'h0, 32'hFFFFFFFE, 1'b0, "lb_FFE");
      n_vec++;
      if (mem[1023] !== 32'hCAFEF00D) begin
         n_err++;
         $display("FAIL top_mem: got %h required CAFEF00D", mem[1023]);
      end
   endtask

   task automatic test_backpressure();
      int waited;
      int c0;
      logic [32:0] exp;
      sb_q.push_back({1'b0, 32'hDE551234});
      @(negedge clk);
      req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 12'h010;
      req_valid = 1'b1; resp_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      c0 = we_cnt;
      req_write = 1'b1; req_wdata = 32'h0BAD0BAD;
      waited = 0;
      while (!resp_valid && waited < 20) begin @(negedge clk); waited++; end
      exp = sb_q.pop_front();
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if ({resp_valid, req_ready} !== 2'b10 || resp_rdata !== exp[31:0]) begin
            n_err++;
            $display("FAIL bp_hold[%0d]: vld=%b rdy=%b rdata=%h required 1 0 %h",
                     i, resp_valid, req_ready, resp_rdata, exp[31:0]);
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({resp_valid, req_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL bp_release: {vld,rdy}=%b required 01", {resp_valid, req_ready});
      end
      n_vec++;
      if (resp_rdata !== exp[31:0] || resp_fault !== 1'b0) begin
         n_err++;
         $display("FAIL bp_keep: rdata=%h fault=%b required %h 0", resp_rdata, resp_fault, exp[31:0]);
      end
      n_vec++;
      if (we_cnt !== c0 || mem[4] !== 32'hDE551234) begin
         n_err++;
         $display("FAIL bp_no_accept: pulses=%0d mem=%h required 0 DE551234", we_cnt - c0, mem[4]);
      end
   endtask

   task automatic test_reset_mid_access();
      @(negedge clk);
      req_write = 1'b1; req_size = 2'd2; req_signed = 1'b0; req_addr = 12'h020;
      req_wdata = 32'hAAAAAAAA; req_valid = 1'b1; resp_ready = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      n_vec++;
      if (dm_write_enable !== 1'b1) begin
         n_err++;
         $display("FAIL rst_mid_we_before: got %b required 1", dm_write_enable);
      end
      reset_n = 1'b0;
      #1;
      n_vec++;
      if ({req_ready, resp_valid, resp_fault, dm_write_enable} !== 4'b1000) begin
         n_err++;
         $display("FAIL rst_mid_ctrl: {rdy,rvld,flt,we}=%b required 1000",
                  {req_ready, resp_valid, resp_fault, dm_write_enable});
      end
      n_vec++;
      if ({resp_rdata, dm_write_data, dm_read_addr, dm_write_addr} !== 84'd0) begin
         n_err++;
         $display("FAIL rst_mid_data: rdata=%h wdata=%h raddr=%h waddr=%h required all 0",
                  resp_rdata, dm_write_data, dm_read_addr, dm_write_addr);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (mem[8] !== 32'h13579BDF) begin
         n_err++;
         $display("FAIL rst_mid_mem: got %h required 13579BDF", mem[8]);
      end
      @(negedge clk);
      reset_n = 1'b1;
      do_req(1'b0, 2'd2, 1'b0, 12'h020, 32'h0, 32'h13579BDF, 1'b0, "lw_020_after_rst");
   endtask

   initial begin
      test_reset();
      test_word();
      test_subword_store();
      test_loads();
      test_faults();
      test_top_word();
      test_backpressure();
      test_reset_mid_access();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
